// File: rtl/rv6_pkg.sv
// rv6_pkg: opcodes, ALU ops, FSM states and CSR numbers shared by the rv6 hart
package rv6_pkg;
  localparam logic [6:0] LOAD = 7'h03, MISC_MEM = 7'h0f, OP_IMM = 7'h13, AUIPC = 7'h17,
                         OP_IMM_32 = 7'h1b, STORE = 7'h23, OP = 7'h33, LUI = 7'h37,
                         OP_32 = 7'h3b, BRANCH = 7'h63, JALR = 7'h67, JAL = 7'h6f, SYSTEM = 7'h73;
  localparam logic [11:0] CSR_MHARTID = 12'hf14, CSR_MCYCLE = 12'hb00, CSR_MINSTRET = 12'hb02;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_LOAD, S_LOCK, S_ST_RD, S_ST_WR, S_UNLOCK, S_WB
  } state_e;
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv6_alu.sv
// rv6_alu: combinational 64-bit RV64I ALU; w selects the 32-bit sign-extended forms
module rv6_alu
  import rv6_pkg::*;
(
  input  alu_op_e     op,
  input  logic        w,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);
  logic [63:0] x, r;
  logic [5:0] sh;
  always_comb begin
    x = w ? (op == ALU_SRA ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
    sh = w ? {1'b0, b[4:0]} : b[5:0];
    case (op)
      ALU_ADD:  r = x + b;
      ALU_SUB:  r = x - b;
      ALU_SLL:  r = x << sh;
      ALU_SLT:  r = {63'b0, $signed(x) < $signed(b)};
      ALU_SLTU: r = {63'b0, x < b};
      ALU_XOR:  r = x ^ b;
      ALU_SRL:  r = x >> sh;
      ALU_SRA:  r = $signed(x) >>> sh;
      ALU_OR:   r = x | b;
      default:  r = x & b;
    endcase
    y = w ? {{32{r[31]}}, r[31:0]} : r;
  end
endmodule

// File: rtl/rv6_hart.sv
// rv6_hart: multi-cycle RV64I hart on a line-wide bus with locked store RMW; RV6_ZICSR_EN adds mhartid/mcycle/minstret
module rv6_hart
  import rv6_pkg::*;
#(
  parameter logic [63:0] HART_ID   = 64'd0,
  parameter int          LINE_BITS = 256,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000
) (
  input  logic                 h_clk,
  input  logic                 h_rst,
  output logic [63:0]          h_addr,
  input  logic [LINE_BITS-1:0] h_data_in,
  output logic                 h_rd,
  input  logic                 h_dv,
  output logic [LINE_BITS-1:0] h_data_out,
  output logic                 h_wr,
  input  logic [63:0]          h_inv_addr,
  input  logic                 h_inv,
  output logic                 h_amo_req,
  input  logic                 h_amo_ack
);
  localparam int OB = $clog2(LINE_BITS / 8);
  state_e st;
  alu_op_e aop;
  logic [63:0] rf [32];
  logic [63:0] pc, res, fb_tag, rv1, rv2, imm_i, imm_s, imm_b, imm_u, imm_j, a, b, y, npc, res_c, raw, ld_val, csr_val;
  logic [31:0] ir, fw;
  logic [LINE_BITS-1:0] fb_line, merged;
  logic [OB-1:0] off;
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic fb_valid, w, taken, hit, wen, is_csr;
`ifdef RV6_ZICSR_EN
  logic [63:0] mcycle, minstret;
  assign is_csr = opc == SYSTEM && f3 != 3'd0;
  assign csr_val = ir[31:20] == CSR_MHARTID ? HART_ID : ir[31:20] == CSR_MCYCLE ? mcycle :
                   ir[31:20] == CSR_MINSTRET ? minstret : 64'd0;
  always_ff @(posedge h_clk) begin
    mcycle <= h_rst ? 64'd0 : mcycle + 64'd1;
    minstret <= h_rst ? 64'd0 : minstret + {63'd0, st == S_WB};
  end
`else
  assign is_csr = 1'b0;
  assign csr_val = HART_ID;
`endif
  always_comb begin
    opc = ir[6:0];
    rd = ir[11:7];
    f3 = ir[14:12];
    rs1 = ir[19:15];
    rs2 = ir[24:20];
    rv1 = rf[rs1];
    rv2 = rf[rs2];
    imm_i = {{52{ir[31]}}, ir[31:20]};
    imm_s = {{52{ir[31]}}, ir[31:25], ir[11:7]};
    imm_b = {{52{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    imm_u = {{32{ir[31]}}, ir[31:12], 12'b0};
    imm_j = {{44{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    w = opc == OP_32 || opc == OP_IMM_32;
    aop = (opc == OP || opc == OP_32) ? alu_dec(f3, ir[30]) :
          (opc == OP_IMM || opc == OP_IMM_32) ? alu_dec(f3, ir[30] && f3 == 3'd5) : ALU_ADD;
    a = opc == AUIPC ? pc : opc == LUI ? 64'd0 : rv1;
    b = (opc == OP || opc == OP_32 || opc == BRANCH) ? rv2 : opc == STORE ? imm_s :
        (opc == LUI || opc == AUIPC) ? imm_u : imm_i;
    taken = (f3[2:1] == 2'b00 ? rv1 == rv2 : f3[2:1] == 2'b10 ? $signed(rv1) < $signed(rv2) :
             f3[2:1] == 2'b11 ? rv1 < rv2 : f3[0]) ^ f3[0];
    npc = opc == JAL ? pc + imm_j : opc == JALR ? y & ~64'd1 :
          (opc == BRANCH && taken) ? pc + imm_b : pc + 64'd4;
    res_c = (opc == JAL || opc == JALR) ? pc + 64'd4 : is_csr ? csr_val : y;
    wen = opc == OP || opc == OP_IMM || opc == OP_32 || opc == OP_IMM_32 || opc == LUI ||
          opc == AUIPC || opc == JAL || opc == JALR || opc == LOAD || is_csr;
    hit = fb_valid && fb_tag == (pc >> OB);
    fw = fb_line[{pc[OB-1:2], 5'b0} +: 32];
    off = y[OB-1:0];
  end
  rv6_alu alu (.op(aop), .w(w), .a(a), .b(b), .y(y));
  always_comb begin
    merged = h_data_in;
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = h_data_in[{off + OB'(i), 3'b0} +: 8];
      if (i < (1 << f3[1:0])) merged[{off + OB'(i), 3'b0} +: 8] = rv2[8*i +: 8];
    end
    ld_val = f3[1:0] == 2'd0 ? {{56{~f3[2] & raw[7]}}, raw[7:0]} :
             f3[1:0] == 2'd1 ? {{48{~f3[2] & raw[15]}}, raw[15:0]} :
             f3[1:0] == 2'd2 ? {{32{~f3[2] & raw[31]}}, raw[31:0]} : raw;
  end
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      st <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      res <= '0;
      fb_valid <= 1'b0;
      fb_tag <= '0;
      fb_line <= '0;
      h_addr <= '0;
      h_rd <= 1'b0;
      h_wr <= 1'b0;
      h_data_out <= '0;
      h_amo_req <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (h_inv && (h_inv_addr >> OB) == fb_tag) fb_valid <= 1'b0;
      case (st)
        S_FETCH:
          if (h_rd) begin
            if (h_dv) begin
              h_rd <= 1'b0;
              fb_line <= h_data_in;
              fb_tag <= pc >> OB;
              fb_valid <= !(h_inv && (h_inv_addr >> OB) == (pc >> OB));
            end
          end else if (hit) begin
            ir <= fw;
            st <= S_EXEC;
          end else begin
            h_rd <= 1'b1;
            h_addr <= (pc >> OB) << OB;
          end
        S_EXEC: begin
          res <= res_c;
          st <= opc == LOAD ? S_LOAD : opc == STORE ? S_LOCK : S_WB;
        end
        S_LOAD:
          if (h_rd && h_dv) begin
            h_rd <= 1'b0;
            res <= ld_val;
            st <= S_WB;
          end else begin
            h_rd <= 1'b1;
            h_addr <= (y >> OB) << OB;
          end
        S_LOCK: begin
          h_amo_req <= 1'b1;
          if (h_amo_req && h_amo_ack) st <= S_ST_RD;
        end
        S_ST_RD:
          if (h_rd && h_dv) begin
            h_rd <= 1'b0;
            h_data_out <= merged;
            st <= S_ST_WR;
          end else begin
            h_rd <= 1'b1;
            h_addr <= (y >> OB) << OB;
          end
        S_ST_WR: begin
          h_wr <= 1'b1;
          if (fb_tag == (y >> OB)) fb_valid <= 1'b0;
          st <= S_UNLOCK;
        end
        S_UNLOCK: begin
          h_wr <= 1'b0;
          h_amo_req <= 1'b0;
          st <= S_WB;
        end
        default: begin
          if (wen && rd != 5'd0) rf[rd] <= res;
          pc <= npc;
          st <= S_FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv6_hart.sv
// tb_rv6_hart: directed checks of reset, fetch, ALU, locked store RMW, invalidation and CSR read
`timescale 1ns/1ps
module tb_rv6_hart;
  logic clk = 1'b0, rst, h_rd, h_dv, h_wr, h_inv, h_amo_req, h_amo_ack;
  logic [63:0] h_addr, h_inv_addr;
  logic [255:0] h_data_in, h_data_out;
  logic [255:0] mem [64];
  int lat, ack_delay, amo_cnt, rd_wait, rd_cyc, wr_cnt, stall, early, both, unlocked_wr, n_pass, n_chk;
  always #5 clk = ~clk;
  rv6_hart #(.HART_ID(64'd3)) dut (
    .h_clk(clk), .h_rst(rst), .h_addr(h_addr), .h_data_in(h_data_in), .h_rd(h_rd), .h_dv(h_dv),
    .h_data_out(h_data_out), .h_wr(h_wr), .h_inv_addr(h_inv_addr), .h_inv(h_inv),
    .h_amo_req(h_amo_req), .h_amo_ack(h_amo_ack)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  task automatic put(input int a, input logic [31:0] w);
    mem[a[10:5]][{a[4:2], 5'b0} +: 32] = w;
  endtask
  task automatic clear();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask
  task automatic boot();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_inv(input logic [63:0] a);
    h_inv_addr = a;
    h_inv = 1'b1;
    @(negedge clk);
    h_inv = 1'b0;
  endtask
  task automatic store_prog();
    clear();
    put(0, 32'h0000_0297);
    put(4, enc_i(12'h080, 5'd5, 3'd3, 5'd6, 7'h03));
    put(8, enc_s(12'h100, 5'd6, 5'd5, 3'd3));
    put(12, enc_i(12'h101, 5'd5, 3'd4, 5'd10, 7'h03));
    put(16, enc_i(12'h102, 5'd5, 3'd1, 5'd11, 7'h03));
    put(20, enc_i(12'h11e, 5'd5, 3'd2, 5'd12, 7'h03));
    put(24, 32'h0000_006f);
    mem[4][63:0] = 64'h1122_3344_5566_7788;
    wr_cnt = 0; stall = 0; early = 0; both = 0; unlocked_wr = 0;
    boot();
    run(400);
  endtask
  initial begin
    h_dv = 1'b0; h_amo_ack = 1'b0; h_data_in = '0; rd_wait = 0; amo_cnt = 0;
    forever begin
      @(negedge clk);
      h_dv = 1'b0;
      if (h_rd) rd_cyc++;
      if (h_rd && h_wr) both++;
      if (h_wr) begin
        mem[h_addr[10:5]] = h_data_out;
        wr_cnt++;
        if (!h_amo_req) unlocked_wr++;
      end
      if (rst) rd_wait = 0;
      else if (h_rd) begin
        if (rd_wait >= lat) begin
          h_data_in = mem[h_addr[10:5]];
          h_dv = 1'b1;
          rd_wait = 0;
        end else rd_wait++;
      end
      if (!h_amo_req) begin
        h_amo_ack = 1'b0;
        amo_cnt = 0;
      end else if (!h_amo_ack) begin
        if (h_rd || h_wr) early++;
        if (amo_cnt >= ack_delay) h_amo_ack = 1'b1;
        else begin
          amo_cnt++;
          stall++;
        end
      end
    end
  end
  initial begin
    rst = 1'b1; h_inv = 1'b0; h_inv_addr = '0; lat = 20; ack_delay = 0;
    n_pass = 0; n_chk = 0; rd_cyc = 0; wr_cnt = 0; stall = 0; early = 0; both = 0; unlocked_wr = 0;
    clear();
    put(0, 32'h0000_006f);
    repeat (2) @(negedge clk);
    check("rst_rd", h_rd, 0);
    check("rst_outs", {h_wr, h_amo_req, h_addr}, 0);
    check("rst_data_out", h_data_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 20 && !h_rd; i++) @(negedge clk);
    check("first_rd", h_rd, 1);
    check("first_addr", h_addr, 64'h8000_0000);
    run(5);
    check("rd_held", h_rd, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {h_rd, h_wr, h_amo_req, h_addr}, 0);
    lat = 2;
    clear();
    put(0, enc_i(12'hfff, 5'd0, 3'd0, 5'd10, 7'h13));
    put(4, enc_i(12'd60, 5'd10, 3'd5, 5'd11, 7'h13));
    put(8, enc_i(12'd0, 5'd10, 3'd0, 5'd12, 7'h1b));
    put(12, enc_i(12'h40a, 5'd11, 3'd0, 5'd13, 7'h33));
    put(16, 32'h0000_0463);
    put(20, enc_i(12'd1, 5'd0, 3'd0, 5'd14, 7'h13));
    put(24, enc_i(12'd7, 5'd0, 3'd0, 5'd15, 7'h13));
    put(28, 32'h0000_006f);
    boot();
    run(200);
    check("addi_a0", dut.rf[10], 64'hffff_ffff_ffff_ffff);
    check("srli_a1", dut.rf[11], 64'hf);
    check("addiw_a2", dut.rf[12], 64'hffff_ffff_ffff_ffff);
    check("sub_x13", dut.rf[13], 64'h10);
    check("beq_skip_x14", dut.rf[14], 64'd0);
    check("beq_target_x15", dut.rf[15], 64'd7);
    rd_cyc = 0;
    run(30);
    check("halt_idle", rd_cyc, 0);
    store_prog();
    check("ld_x6", dut.rf[6], 64'h1122_3344_5566_7788);
    check("st_line", mem[8], 256'h1122_3344_5566_7788);
    check("wr_count", wr_cnt, 1);
    check("wr_locked", unlocked_wr, 0);
    check("lbu_p1", dut.rf[10], 64'h77);
    check("lh_p2", dut.rf[11], 64'h5566);
    check("lw_wrap", dut.rf[12], 64'h7788_0000);
    check("rd_wr_excl", both, 0);
    ack_delay = 10;
    store_prog();
    check("ack_stall", stall >= 10, 1);
    check("ack_no_bus", early, 0);
    check("ack_wr_count", wr_cnt, 1);
    check("ack_lbu", dut.rf[10], 64'h77);
    check("ack_line", mem[8], 256'h1122_3344_5566_7788);
    ack_delay = 0;
    clear();
    put(0, enc_i(12'd5, 5'd0, 3'd0, 5'd10, 7'h13));
    put(4, 32'hffdf_f06f);
    boot();
    run(100);
    check("loop_a0", dut.rf[10], 64'd5);
    rd_cyc = 0;
    run(30);
    check("loop_idle", rd_cyc, 0);
    put(0, enc_i(12'd9, 5'd0, 3'd0, 5'd10, 7'h13));
    pulse_inv(64'h8000_1004);
    run(60);
    check("inv_other_line", dut.rf[10], 64'd5);
    pulse_inv(64'h8000_0004);
    run(60);
    check("inv_patched", dut.rf[10], 64'd9);
    clear();
    put(0, enc_i(12'hf14, 5'd0, 3'd2, 5'd10, 7'h73));
    put(4, 32'h0000_006f);
    boot();
    run(100);
`ifdef RV6_ZICSR_EN
    check("csr_mhartid", dut.rf[10], 64'd3);
`else
    check("csr_disabled", dut.rf[10], 64'd0);
`endif
    rd_cyc = 0;
    run(30);
    check("csr_idle", rd_cyc, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
